// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: passive timing/content checker for a VGA sync stream.
// Measures line/frame geometry, active pixels and a colour checksum per frame.
module vga_frame_monitor #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        btnd,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  rgb,
  output logic [11:0] h_total,
  output logic [11:0] h_sync_w,
  output logic [11:0] v_total,
  output logic [11:0] v_sync_w,
  output logic [19:0] pix_count,
  output logic [15:0] frame_sum,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        locked
);

  localparam logic [11:0] H_TOT = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [11:0] H_SW  = 12'(H_SYNC);
  localparam logic [11:0] H_LO  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_HI  = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [11:0] V_TOT = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [11:0] V_SW  = 12'(V_SYNC);
  localparam logic [11:0] V_LO  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_HI  = 12'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [19:0] PIX_EXP = 20'(H_ACTIVE * V_ACTIVE);
  localparam logic [11:0] SAT   = 12'hFFF;

  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_MEAS = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        hs_p_q, hs_p_d;
  logic        vs_p_q, vs_p_d;
  logic        hseen_q, hseen_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] hs_w_q, hs_w_d;
  logic        line_err_q, line_err_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [11:0] vs_w_q, vs_w_d;
  logic [19:0] pcnt_q, pcnt_d;
  logic [15:0] sum_q, sum_d;
  logic        ferr_q, ferr_d;
  logic [1:0]  good_q, good_d;

  logic [11:0] h_total_q, h_total_d;
  logic [11:0] h_sync_w_q, h_sync_w_d;
  logic [11:0] v_total_q, v_total_d;
  logic [11:0] v_sync_w_q, v_sync_w_d;
  logic [19:0] pix_count_q, pix_count_d;
  logic [15:0] frame_sum_q, frame_sum_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic        locked_q, locked_d;

  logic        hs_a, vs_a, hs_le, vs_le;
  logic        active, ok;
  logic [1:0]  good_n;

  assign h_total    = h_total_q;
  assign h_sync_w   = h_sync_w_q;
  assign v_total    = v_total_q;
  assign v_sync_w   = v_sync_w_q;
  assign pix_count  = pix_count_q;
  assign frame_sum  = frame_sum_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign locked     = locked_q;

  // Per-sample measurement, line/frame checks and frame-boundary publish.
  always_comb begin
    state_d      = state_q;
    hs_p_d       = hs_p_q;
    vs_p_d       = vs_p_q;
    hseen_d      = hseen_q;
    hcnt_d       = hcnt_q;
    hs_w_d       = hs_w_q;
    line_err_d   = line_err_q;
    vcnt_d       = vcnt_q;
    vs_w_d       = vs_w_q;
    pcnt_d       = pcnt_q;
    sum_d        = sum_q;
    ferr_d       = ferr_q;
    good_d       = good_q;
    h_total_d    = h_total_q;
    h_sync_w_d   = h_sync_w_q;
    v_total_d    = v_total_q;
    v_sync_w_d   = v_sync_w_q;
    pix_count_d  = pix_count_q;
    frame_sum_d  = frame_sum_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    locked_d     = locked_q;
    hs_a   = (hsync == SYNC_POL);
    vs_a   = (vsync == SYNC_POL);
    hs_le  = hs_a & ~hs_p_q;
    vs_le  = vs_a & ~vs_p_q;
    active = 1'b0;
    ok     = 1'b0;
    good_n = good_q;
    if (pix_en) begin
      hs_p_d = hs_a;
      vs_p_d = vs_a;
      if (hs_le) begin
        hcnt_d  = '0;
        hs_w_d  = 12'd1;
        hseen_d = 1'b1;
        if (hseen_q) begin
          h_total_d  = hcnt_q + 12'd1;
          h_sync_w_d = hs_w_q;
          if ((hcnt_q + 12'd1) != H_TOT || hs_w_q != H_SW)
            ferr_d = 1'b1;
        end
        if (vcnt_q != SAT)
          vcnt_d = vcnt_q + 12'd1;
        if (vs_a && vs_w_q != SAT)
          vs_w_d = vs_w_q + 12'd1;
      end else begin
        if (hcnt_q == SAT)
          line_err_d = 1'b1;
        else
          hcnt_d = hcnt_q + 12'd1;
        if (hs_a && hs_w_q != SAT)
          hs_w_d = hs_w_q + 12'd1;
      end
      // A frame start also restarts line numbering for this sample.
      if (vs_le) begin
        vcnt_d = '0;
        vs_w_d = hs_le ? 12'd1 : 12'd0;
      end
      active = (hcnt_d >= H_LO) && (hcnt_d <= H_HI) &&
               (vcnt_d >= V_LO) && (vcnt_d <= V_HI);
      if (vs_le) begin
        ok = !ferr_d && !line_err_d &&
             ((vcnt_q + 12'd1) == V_TOT) &&
             (vs_w_q == V_SW) && (pcnt_q == PIX_EXP);
        if (state_q == S_MEAS) begin
          good_n = ok ? ((good_q == 2'd3) ? 2'd3 : good_q + 2'd1)
                      : 2'd0;
          v_total_d    = vcnt_q + 12'd1;
          v_sync_w_d   = vs_w_q;
          pix_count_d  = pcnt_q;
          frame_sum_d  = sum_q;
          frame_ok_d   = ok;
          good_d       = good_n;
          locked_d     = (good_n >= 2'd2);
          frame_done_d = 1'b1;
        end
        state_d    = S_MEAS;
        pcnt_d     = active ? 20'd1 : 20'd0;
        sum_d      = active ? {8'd0, rgb} : 16'd0;
        ferr_d     = 1'b0;
        line_err_d = 1'b0;
      end else if (active) begin
        pcnt_d = pcnt_q + 20'd1;
        sum_d  = sum_q + {8'd0, rgb};
      end
    end
  end

  // State and output registers; btnd discards everything including a partial frame.
  always_ff @(posedge clk) begin
    if (btnd) begin
      state_q      <= S_WAIT;
      hs_p_q       <= 1'b0;
      vs_p_q       <= 1'b0;
      hseen_q      <= 1'b0;
      hcnt_q       <= '0;
      hs_w_q       <= '0;
      line_err_q   <= 1'b0;
      vcnt_q       <= '0;
      vs_w_q       <= '0;
      pcnt_q       <= '0;
      sum_q        <= '0;
      ferr_q       <= 1'b0;
      good_q       <= '0;
      h_total_q    <= '0;
      h_sync_w_q   <= '0;
      v_total_q    <= '0;
      v_sync_w_q   <= '0;
      pix_count_q  <= '0;
      frame_sum_q  <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_p_q       <= hs_p_d;
      vs_p_q       <= vs_p_d;
      hseen_q      <= hseen_d;
      hcnt_q       <= hcnt_d;
      hs_w_q       <= hs_w_d;
      line_err_q   <= line_err_d;
      vcnt_q       <= vcnt_d;
      vs_w_q       <= vs_w_d;
      pcnt_q       <= pcnt_d;
      sum_q        <= sum_d;
      ferr_q       <= ferr_d;
      good_q       <= good_d;
      h_total_q    <= h_total_d;
      h_sync_w_q   <= h_sync_w_d;
      v_total_q    <= v_total_d;
      v_sync_w_q   <= v_sync_w_d;
      pix_count_q  <= pix_count_d;
      frame_sum_q  <= frame_sum_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      locked_q     <= locked_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: scoreboard bench for vga_frame_monitor.
// Uses a reduced raster (82x15) so whole frames fit a short run.
module tb_vga_frame_monitor;

  localparam int HA = 64;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 6;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = 82;
  localparam int VT = 15;
  localparam logic SP = 1'b0;

  logic        clk = 1'b0;
  logic        btnd = 1'b1;
  logic        pix_en = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [7:0]  rgb = 8'd0;
  logic [11:0] h_total, h_sync_w, v_total, v_sync_w;
  logic [19:0] pix_count;
  logic [15:0] frame_sum;
  logic        frame_done, frame_ok, locked;

  vga_frame_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP)
  ) dut (
    .clk(clk), .btnd(btnd), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .h_total(h_total), .h_sync_w(h_sync_w),
    .v_total(v_total), .v_sync_w(v_sync_w),
    .pix_count(pix_count), .frame_sum(frame_sum),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        full;
    logic [11:0] ht;
    logic [11:0] hsw;
    logic [11:0] vt;
    logic [11:0] vsw;
    logic [19:0] pc;
    logic [15:0] fs;
    logic        ok;
    logic        lk;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   div = 1;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic exp_t nom(input logic [15:0] fs, input logic ok,
                               input logic lk);
    exp_t r;
    r.full = 1'b1;
    r.ht = 12'd82;
    r.hsw = 12'd8;
    r.vt = 12'd15;
    r.vsw = 12'd2;
    r.pc = 20'd512;
    r.fs = fs;
    r.ok = ok;
    r.lk = lk;
    return r;
  endfunction

  function automatic exp_t part(input logic [11:0] hsw, input logic ok,
                                input logic lk);
    exp_t r;
    r = '0;
    r.hsw = hsw;
    r.ok = ok;
    r.lk = lk;
    return r;
  endfunction

  // Monitor: every frame_done pops one expectation.
  always @(negedge clk) begin
    if (prev_done)
      chk("done_width", 32'(frame_done), 32'd0);
    prev_done <= frame_done;
    if (frame_done === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got pulse, expected none");
      end else begin
        e = q.pop_front();
        chk("frame_ok", 32'(frame_ok), 32'(e.ok));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("h_sync_w", 32'(h_sync_w), 32'(e.hsw));
        if (e.full) begin
          chk("h_total", 32'(h_total), 32'(e.ht));
          chk("v_total", 32'(v_total), 32'(e.vt));
          chk("v_sync_w", 32'(v_sync_w), 32'(e.vsw));
          chk("pix_count", 32'(pix_count), 32'(e.pc));
          chk("frame_sum", 32'(frame_sum), 32'(e.fs));
        end
      end
    end
  end

  task automatic chk_zero(input string t);
    chk({t, "_h_total"}, 32'(h_total), 32'd0);
    chk({t, "_h_sync_w"}, 32'(h_sync_w), 32'd0);
    chk({t, "_v_total"}, 32'(v_total), 32'd0);
    chk({t, "_v_sync_w"}, 32'(v_sync_w), 32'd0);
    chk({t, "_pix_count"}, 32'(pix_count), 32'd0);
    chk({t, "_frame_sum"}, 32'(frame_sum), 32'd0);
    chk({t, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({t, "_frame_ok"}, 32'(frame_ok), 32'd0);
    chk({t, "_locked"}, 32'(locked), 32'd0);
  endtask

  task automatic rst_pulse(input string t);
    pix_en = 1'b0;
    btnd = 1'b1;
    @(negedge clk);
    btnd = 1'b0;
    chk_zero(t);
  endtask

  // One pixel sample; idle cycles carry junk that must be ignored.
  task automatic smp(input logic ha, input logic va, input logic [7:0] c,
                     input logic inv);
    for (int i = 0; i < div - 1; i++) begin
      pix_en = 1'b0;
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      rgb = 8'($urandom);
      @(negedge clk);
    end
    pix_en = 1'b1;
    hsync = (ha ^ inv) ? SP : ~SP;
    vsync = (va ^ inv) ? SP : ~SP;
    rgb = c;
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] c, input logic inv,
                       input int short_ln, input logic stuck,
                       input int rst_ln, input logic pub, input exp_t x);
    int len;
    logic stop;
    stop = 1'b0;
    if (pub)
      q.push_back(x);
    for (int l = 0; l < VT; l++) begin
      if (!stop) begin
        if (stuck && l == 4) begin
          for (int k = 0; k < 5000; k++)
            smp(1'b0, 1'b0, c, 1'b0);
          stop = 1'b1;
        end else begin
          len = (l == short_ln) ? HT - 1 : HT;
          for (int p = 0; p < len; p++) begin
            if (l == rst_ln && p == 30)
              rst_pulse("midrst");
            smp(p < HS, l < VS, c, inv);
          end
        end
      end
    end
  endtask

  initial begin
    btnd = 1'b1;
    repeat (3) begin
      pix_en = 1'($urandom);
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      rgb = 8'($urandom);
      @(negedge clk);
    end
    chk_zero("reset");
    btnd = 1'b0;
    pix_en = 1'b0;

    div = 4;
    frame(8'h01, 1'b0, -1, 1'b0, -1, 1'b0, nom(16'h0, 1'b0, 1'b0));
    frame(8'h01, 1'b0, -1, 1'b0, -1, 1'b1, nom(16'h0200, 1'b1, 1'b0));
    frame(8'hFF, 1'b0, -1, 1'b0, -1, 1'b1, nom(16'h0200, 1'b1, 1'b1));

    div = 1;
    frame(8'h5A, 1'b0, 6, 1'b0, -1, 1'b1, nom(16'hFE00, 1'b1, 1'b1));
    frame(8'h5A, 1'b0, -1, 1'b0, -1, 1'b1, nom(16'hB400, 1'b0, 1'b0));
    frame(8'h5A, 1'b0, -1, 1'b0, -1, 1'b1, nom(16'hB400, 1'b1, 1'b0));
    frame(8'h3C, 1'b0, -1, 1'b0, -1, 1'b1, nom(16'hB400, 1'b1, 1'b1));

    frame(8'h01, 1'b0, -1, 1'b1, -1, 1'b1, nom(16'h7800, 1'b1, 1'b1));
    frame(8'h01, 1'b0, -1, 1'b0, -1, 1'b1, part(12'd8, 1'b0, 1'b0));
    frame(8'h01, 1'b0, -1, 1'b0, -1, 1'b1, nom(16'h0200, 1'b1, 1'b0));

    frame(8'h01, 1'b0, -1, 1'b0, 8, 1'b1, nom(16'h0200, 1'b1, 1'b1));
    frame(8'h01, 1'b0, -1, 1'b0, -1, 1'b0, nom(16'h0, 1'b0, 1'b0));
    frame(8'h01, 1'b0, -1, 1'b0, -1, 1'b1, nom(16'h0200, 1'b1, 1'b0));

    rst_pulse("polrst");
    frame(8'h01, 1'b1, -1, 1'b0, -1, 1'b0, part(12'd0, 1'b0, 1'b0));
    frame(8'h01, 1'b1, -1, 1'b0, -1, 1'b1, part(12'd74, 1'b0, 1'b0));

    pix_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

- Passive checker on the VGA output of `super`.
- Samples `hsync`, `vsync` and `rgb` on pixel-enable cycles.
- Per frame, it measures the horizontal and vertical totals and the sync pulse widths, counts active pixels, and accumulates a 16-bit colour checksum.
- At each frame boundary it publishes the results, a pass/fail flag and a lock indication, so a bench or on-board debug path can check the display without a monitor.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, hsync pulse width, in pixels
- `H_BP`, 48, horizontal back porch, in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vsync pulse width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `SYNC_POL`, 0, asserted level of both syncs (0 = active low)

Ports:
- `clk`  in  1  system clock; the only clock
- `btnd`  in  1  reset; synchronous, active-high
- `pix_en`  in  1  pixel strobe; inputs are sampled only on cycles where this is 1
- `hsync`  in  1  horizontal sync, synchronous to `clk`
- `vsync`  in  1  vertical sync, synchronous to `clk`
- `rgb`  in  8  pixel colour
- `h_total`  out  12  length of the last complete line, in pixels
- `h_sync_w`  out  12  hsync width of the last complete line
- `v_total`  out  12  lines in the last frame
- `v_sync_w`  out  12  vsync width of the last frame, in lines
- `pix_count`  out  20  active pixels in the last frame
- `frame_sum`  out  16  sum of `rgb` over active pixels, mod 2^16
- `frame_done`  out  1  one-`clk` pulse when the outputs above update
- `frame_ok`  out  1  last frame matched all parameters
- `locked`  out  1  two or more consecutive good frames

## Operation
**Sync detection**
- `hs_a = (hsync == SYNC_POL)`; `vs_a` is defined the same way for `vsync`.
- Previous-sample registers update only on `pix_en`.
- A leading edge (LE) is a sample where the signal is asserted and the previous sample was not.

**Horizontal**
- `hcnt` is set to 0 on an hsync LE and increments on every other sample. It saturates at 4095; saturation sets `line_err`.
- `hs_w` counts asserted samples since the LE.
- On an hsync LE: latch `h_total = hcnt+1` and `h_sync_w = hs_w`.
  - If `h_total ≠ H_SYNC+H_BP+H_ACTIVE+H_FP` or `h_sync_w ≠ H_SYNC`, set the frame error flag `ferr`.
  - The first LE after reset latches nothing.

**Vertical**
- `vcnt` increments on each hsync LE.
- `vs_w` counts hsync LEs seen while `vs_a` is asserted.
- On a vsync LE, `vcnt` is set to 0. When a vsync LE and an hsync LE occur on the same sample, the vsync action wins.

**Active window**
- A sample is active when `hcnt` is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and `vcnt` is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- Each active sample: `pcnt += 1` and `sum += rgb` (zero-extended, 16-bit wrap).

**Frame boundary (vsync LE) state machine**
- States:
  - **WAIT_SYNC**: after reset; first vsync LE → MEASURE; no publish.
  - **MEASURE**: every vsync LE publishes and stays in MEASURE.
- Publish action:
  - Copy `vcnt`+1, `vs_w`, `pcnt` and `sum` to `v_total`, `v_sync_w`, `pix_count` and `frame_sum`.
  - `frame_ok = !ferr && !line_err && v_total == V_total && v_sync_w == V_SYNC && pix_count == H_ACTIVE*V_ACTIVE`.
  - Pulse `frame_done`, then clear the accumulators and `ferr`.
- Lock tracking (2-bit `good` counter, saturating):
  - Increments on a good frame and clears on a bad one.
  - `locked = (good >= 2)`.

**Reset**
- `btnd` high clears every register and output to 0, and the state machine returns to WAIT_SYNC.
- This applies mid-frame as well: the partial frame is discarded and never published.

## Timing
- All outputs are registered.
- `frame_done` rises on the `clk` edge after the `pix_en` cycle that samples the vsync LE. It stays high for exactly one `clk` cycle, regardless of the `pix_en` rate.
- `h_total` and `h_sync_w` update one `clk` after the sample containing the hsync LE.
- Published values are stable from the `frame_done` cycle until the next publish.
- `frame_ok` and `locked` update in the same cycle as `frame_done`.
- `pix_en` may be continuously high (a 1-clk pixel) or periodic; no minimum gap is required.
- All output values are 0 from the cycle after `btnd` is sampled high.

## Test plan
1. **Reset**: hold `btnd`=1 for 3 clk with random inputs → every output is 0 and no `frame_done`.
2. **Nominal frame**: ideal 640x480 timing, `pix_en` every 4th clk, `rgb`=0x01.
   - The first vsync LE produces no pulse.
   - The second LE pulses `frame_done` with `h_total`=800, `h_sync_w`=96, `v_total`=525, `v_sync_w`=2, `pix_count`=307200, `frame_sum`=0xB000, `frame_ok`=1, `locked`=0.
   - The third LE gives `locked`=1.
3. **Short line**: in a locked stream, one line is 799 pixels → that frame publishes `frame_ok`=0 and `locked`=0. The next two good frames restore `locked`=1.
4. **Wrong polarity**: syncs inverted relative to `SYNC_POL` → `h_sync_w`=704 and `frame_ok`=0.
5. **Mid-frame reset**: `btnd` pulsed at line 200 → all outputs are 0 next cycle. The next vsync LE gives no `frame_done`; the following one gives a good frame.
6. **Stuck hsync**: hsync held deasserted for 5000 samples, then a vsync LE → `frame_ok`=0 due to the saturated `hcnt`.
